// File: rtl/xcvr_pkg.sv
// rtl/xcvr_pkg.sv - shared constants and state encoding for the transceiver transfer engine
package xcvr_pkg;
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_READ  = 3'b010;
  localparam logic [2:0] ST_WRITE = 3'b100;

  localparam int FT_BYTES_PER_WORD  = 4;
  localparam int FT_WORD_W          = 32;
  localparam int FT_CNT_W           = 10;
  localparam int FT_TO_W            = 20;
  localparam int FT_TIMEOUT_DEFAULT = 1_000_000;

  typedef logic [FT_WORD_W-1:0] ft_word_t;
endpackage

// File: rtl/xcvr_ft_engine_if.sv
// rtl/xcvr_ft_engine_if.sv - request/response and SPI byte signals of the transfer engine
interface xcvr_ft_engine_if
  import xcvr_pkg::*;
();
  logic                rd_req;
  logic [FT_CNT_W-1:0] rd_word_cnt;
  logic                wr_req;
  ft_word_t            wr_data;
  logic                rd_rdy;
  logic                wr_rdy;
  ft_word_t            rd_data;
  logic                ft_data_valid;
  logic                ft_done;
  logic                ft_err;
  logic                ft_req_err;
  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic [7:0]          tx_byte;
  logic                tx_valid;
  logic                tx_ready;
  logic                rx_drop;

  modport master (
    output rd_req, rd_word_cnt, wr_req, wr_data, rx_byte, rx_valid, tx_ready,
    input  rd_rdy, wr_rdy, rd_data, ft_data_valid, ft_done, ft_err, ft_req_err,
           tx_byte, tx_valid, rx_drop
  );

  modport slave (
    input  rd_req, rd_word_cnt, wr_req, wr_data, rx_byte, rx_valid, tx_ready,
    output rd_rdy, wr_rdy, rd_data, ft_data_valid, ft_done, ft_err, ft_req_err,
           tx_byte, tx_valid, rx_drop
  );
endinterface

// File: rtl/xcvr_tx_serializer.sv
// rtl/xcvr_tx_serializer.sv - loads a 32-bit word and hands it out LSB byte first over valid/ready
module xcvr_tx_serializer
  import xcvr_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_nrst,
  input  logic       i_load,
  input  ft_word_t   i_data,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_valid,
  output logic       o_last_hs,
  output logic       o_done
);
  ft_word_t   r_shift;
  logic [1:0] r_idx;
  logic       r_valid;
  logic       r_done;
  logic       w_hs;

  assign w_hs       = r_valid & i_tx_ready;
  assign o_last_hs  = w_hs & (r_idx == 2'(FT_BYTES_PER_WORD - 1));
  assign o_tx_byte  = r_shift[7:0];
  assign o_tx_valid = r_valid;
  assign o_done     = r_done;

  // The shift register only moves on a handshake, so the byte on offer is stable while stalled.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= o_last_hs;
      if (i_load) begin
        r_shift <= i_data;
        r_idx   <= '0;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_shift <= {8'h00, r_shift[FT_WORD_W-1:8]};
        r_idx   <= r_idx + 2'd1;
        if (o_last_hs) r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/xcvr_ft_engine.sv
// rtl/xcvr_ft_engine.sv - word transfer engine between the command FSM and the SPI slave byte layer
// Optional inter-byte read timeout is built when XCVR_FT_TIMEOUT_EN is defined.
module xcvr_ft_engine
  import xcvr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = FT_TIMEOUT_DEFAULT
) (
  input logic             sys_clk,
  input logic             sys_nrst,
  xcvr_ft_engine_if.slave bus
);
  localparam int CW = FT_CNT_W + 1;

  logic [2:0]    r_state;
  logic [CW-1:0] r_word_cnt;
  logic [1:0]    r_byte_idx;
  ft_word_t      r_asm;
  ft_word_t      r_rd_data;
  logic          r_rdy, r_data_valid, r_rd_done, r_ft_err, r_req_err, r_rx_drop;
  logic          w_idle, w_in_read, w_rd_go, w_wr_go, w_req_err;
  logic          w_word_end, w_last_word, w_abort, w_last_hs, w_ser_done;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_in_read   = (r_state == ST_READ);
  assign w_rd_go     = w_idle & bus.rd_req;
  assign w_wr_go     = w_idle & bus.wr_req & ~bus.rd_req;
  assign w_req_err   = (w_idle & bus.rd_req & bus.wr_req) | (~w_idle & (bus.rd_req | bus.wr_req));
  assign w_word_end  = w_in_read & bus.rx_valid & (r_byte_idx == 2'(FT_BYTES_PER_WORD - 1));
  assign w_last_word = w_word_end & (r_word_cnt == CW'(1));

`ifdef XCVR_FT_TIMEOUT_EN
  logic [FT_TO_W-1:0] r_to_cnt;
  logic               r_to_tog;

  assign w_abort = w_in_read & ~bus.rx_valid & (r_to_cnt == FT_TO_W'(TIMEOUT_CYCLES - 1));

  // Counts every other cycle of silence while reading; any received byte restarts it.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      r_to_cnt <= '0;
      r_to_tog <= 1'b0;
    end else if (~w_in_read | bus.rx_valid) begin
      r_to_cnt <= '0;
      r_to_tog <= 1'b0;
    end else begin
      r_to_tog <= ~r_to_tog;
      if (r_to_tog) r_to_cnt <= r_to_cnt + FT_TO_W'(1);
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  xcvr_tx_serializer u_tx (
    .sys_clk    (sys_clk),
    .sys_nrst   (sys_nrst),
    .i_load     (w_wr_go),
    .i_data     (bus.wr_data),
    .i_tx_ready (bus.tx_ready),
    .o_tx_byte  (bus.tx_byte),
    .o_tx_valid (bus.tx_valid),
    .o_last_hs  (w_last_hs),
    .o_done     (w_ser_done)
  );

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      r_state      <= ST_IDLE;
      r_word_cnt   <= '0;
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_rd_data    <= '0;
      r_rdy        <= 1'b0;
      r_data_valid <= 1'b0;
      r_rd_done    <= 1'b0;
      r_ft_err     <= 1'b0;
      r_req_err    <= 1'b0;
      r_rx_drop    <= 1'b0;
    end else begin
      r_rdy        <= w_idle & ~w_rd_go & ~w_wr_go;
      r_data_valid <= w_word_end;
      r_rd_done    <= w_last_word | w_abort;
      r_ft_err     <= w_abort;
      r_req_err    <= w_req_err;
      r_rx_drop    <= bus.rx_valid & ~w_in_read;
      case (r_state)
        ST_IDLE: begin
          if (w_rd_go) begin
            r_state    <= ST_READ;
            r_word_cnt <= (bus.rd_word_cnt == '0) ? {1'b1, {FT_CNT_W{1'b0}}} : CW'(bus.rd_word_cnt);
            r_byte_idx <= '0;
          end else if (w_wr_go) begin
            r_state    <= ST_WRITE;
            r_byte_idx <= '0;
          end
        end
        ST_READ: begin
          // Bytes enter at the top and move down, so byte 0 ends up in bits [7:0].
          if (bus.rx_valid) begin
            r_asm      <= {bus.rx_byte, r_asm[FT_WORD_W-1:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_word_end) begin
              r_rd_data  <= {bus.rx_byte, r_asm[FT_WORD_W-1:8]};
              r_word_cnt <= r_word_cnt - CW'(1);
              if (w_last_word) r_state <= ST_IDLE;
            end
          end else if (w_abort) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= '0;
          end
        end
        ST_WRITE: begin
          if (w_last_hs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_rdy        = r_rdy;
  assign bus.wr_rdy        = r_rdy;
  assign bus.rd_data       = r_rd_data;
  assign bus.ft_data_valid = r_data_valid;
  assign bus.ft_done       = r_rd_done | w_ser_done;
  assign bus.ft_err        = r_ft_err;
  assign bus.ft_req_err    = r_req_err;
  assign bus.rx_drop       = r_rx_drop;
endmodule
